// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: VGA receive bus between a raster source (master) and the decoder (slave)
// Signals: pix_stb/hsync/vsync/rgb from the source (syncs active low, rgb = {R,G,B} nibbles);
// x/y/pix_valid/pix_rgb/frame_start/locked/err/frame_crc from the decoder.
interface vga_sync_decoder_if;
  logic        pix_stb;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pix_valid;
  logic [11:0] pix_rgb;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [15:0] frame_crc;
  modport master (
    output pix_stb, hsync, vsync, rgb,
    input  x, y, pix_valid, pix_rgb, frame_start, locked, err, frame_crc
  );
  modport slave (
    input  pix_stb, hsync, vsync, rgb,
    output x, y, pix_valid, pix_rgb, frame_start, locked, err, frame_crc
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel x/y from a VGA raster, checks line/frame timing, reports lock/errors
// Ports: i_clk (system clock), i_rst_n (async active-low reset), bus (vga_sync_decoder_if.slave):
//   inputs pix_stb/hsync/vsync/rgb, outputs x/y/pix_valid/pix_rgb/frame_start/locked/err/frame_crc.
// Optional: define VGA_DECODER_CRC_EN for a per-frame CRC-16-CCITT of the valid pixels on frame_crc.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1024
) (
  input logic               i_clk,
  input logic               i_rst_n,
  vga_sync_decoder_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int GW      = $clog2(LOCK_FRAMES + 1);
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  state_t        state;
  logic [GW-1:0] good;
  logic          hs_q, vs_q, tmo_hold;
  logic [9:0]    hcnt, vcnt, hcnt_n, vcnt_n;
  logic          hfall, hrise, vfall, tmo, viol, active;
  always_comb begin
    hfall  = bus.pix_stb & hs_q & ~bus.hsync;
    hrise  = bus.pix_stb & ~hs_q & bus.hsync;
    vfall  = bus.pix_stb & vs_q & ~bus.vsync;
    hcnt_n = hfall ? '0 : (hcnt == 10'(TIMEOUT - 1)) ? hcnt : hcnt + 10'd1;
    vcnt_n = vfall ? '0 : (hfall && vcnt != '1) ? vcnt + 10'd1 : vcnt;
    // fires once when the line runs to TIMEOUT strobes; tmo_hold mutes it until the next hsync fall
    tmo    = bus.pix_stb & ~hfall & ~tmo_hold & (hcnt == 10'(TIMEOUT - 1));
    // hcnt/vcnt still hold the previous strobe's values, i.e. the length just completed
    viol   = tmo | ((state != SEARCH) &
             ((hfall & (hcnt != 10'(H_TOTAL - 1))) |
              (hrise & (hcnt != 10'(H_SYNC - 1))) |
              (vfall & (~hfall | (vcnt != 10'(V_TOTAL - 1))))));
    active = bus.pix_stb &
             (hcnt_n >= 10'(H_START)) & (hcnt_n < 10'(H_START + H_ACTIVE)) &
             (vcnt_n >= 10'(V_START)) & (vcnt_n < 10'(V_START + V_ACTIVE));
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= SEARCH;
      good            <= '0;
      hs_q            <= 1'b0;
      vs_q            <= 1'b0;
      tmo_hold        <= 1'b0;
      hcnt            <= '0;
      vcnt            <= '0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.pix_valid   <= 1'b0;
      bus.pix_rgb     <= '0;
      bus.frame_start <= 1'b0;
      bus.locked      <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.err         <= viol;
      bus.pix_valid   <= active & ~viol & (state == LOCKED);
      bus.frame_start <= 1'b0;
      if (bus.pix_stb) begin
        hs_q     <= bus.hsync;
        vs_q     <= bus.vsync;
        hcnt     <= hcnt_n;
        vcnt     <= vcnt_n;
        tmo_hold <= ~hfall & (tmo_hold | tmo);
      end
      if (active) begin
        bus.x       <= hcnt_n - 10'(H_START);
        bus.y       <= vcnt_n - 10'(V_START);
        bus.pix_rgb <= bus.rgb;
      end
      if (viol) begin
        state      <= SEARCH;
        bus.locked <= 1'b0;
      end else if (vfall) begin
        if (state == SEARCH) begin
          state <= ALIGN;
          good  <= '0;
        end else if (state == LOCKED || int'(good) == LOCK_FRAMES - 1) begin
          state           <= LOCKED;
          bus.locked      <= 1'b1;
          bus.frame_start <= 1'b1;
        end else
          good <= good + GW'(1);
      end
    end
  end
`ifdef VGA_DECODER_CRC_EN
  logic [15:0] crc;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc           <= 16'hFFFF;
      bus.frame_crc <= '0;
    end else if (vfall) begin
      bus.frame_crc <= crc;
      crc           <= 16'hFFFF;
    end else if (bus.pix_valid)
      crc <= crc_step(crc, {4'h0, bus.pix_rgb});
  end
`else
  assign bus.frame_crc = '0;
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: frame-level directed vectors on a reduced 16x9 raster plus timeout and reset sequences
module tb_vga_sync_decoder;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3, VA = 4, VF = 1, VS = 2, VB = 2, TO = 40;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  localparam int HST = HS + HB, VST = VS + VB;
  localparam int NREC = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  vga_sync_decoder_if bus();
  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LOCK_FRAMES(2), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {
    int          mode;
    logic [11:0] rgb;
    int          short_l;
    int          valid;
    int          fs;
    int          err;
    int          locked;
  } rec_t;
  rec_t tab [NREC];
  int checks = 0, failures = 0;
  int n_valid = 0, n_fs = 0, n_err = 0, n_bad = 0;
  int mark = 0, mode = 0;
  logic [11:0] cur_rgb = 12'h000;
  logic [9:0]  fx, fy, lx, ly;
  logic [11:0] lrgb;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pix_valid) begin
        n_valid <= n_valid + 1;
        if (n_valid == mark) begin
          fx <= bus.x;
          fy <= bus.y;
        end
        lx   <= bus.x;
        ly   <= bus.y;
        lrgb <= bus.pix_rgb;
        if ((mode == 1) ? (bus.pix_rgb != {bus.x[3:0], bus.y[3:0], 4'h0} || bus.x >= 10'(HA) || bus.y >= 10'(VA))
                        : (bus.pix_rgb != cur_rgb))
          n_bad <= n_bad + 1;
      end
      if (bus.frame_start) n_fs <= n_fs + 1;
      if (bus.err) n_err <= n_err + 1;
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int outs_nz();
    return int'(|{bus.x, bus.y, bus.pix_valid, bus.pix_rgb, bus.frame_start, bus.locked, bus.err, bus.frame_crc});
  endfunction
  function automatic logic [15:0] crc_zero_words(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    repeat (n) for (int i = 0; i < 16; i++) c = {c[14:0], 1'b0} ^ (c[15] ? 16'h1021 : 16'h0000);
    return c;
  endfunction
  task automatic strobe(input logic h, input logic v, input logic [11:0] c);
    @(negedge clk);
    bus.pix_stb = 1'b1;
    bus.hsync   = h;
    bus.vsync   = v;
    bus.rgb     = c;
    @(negedge clk);
    bus.pix_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic frame(input int short_l);
    logic [11:0] c;
    for (int l = 0; l < VT; l++)
      for (int h = 0; h < ((l == short_l) ? HT - 1 : HT); h++) begin
        c = (mode != 1) ? cur_rgb :
            (h >= HST && h < HST + HA && l >= VST && l < VST + VA) ? {4'(h - HST), 4'(l - VST), 4'h0} : 12'h000;
        strobe(h >= HS, l >= VS, c);
      end
  endtask
  task automatic apply(input int i);
    int v0, f0, e0, b0;
    v0 = n_valid; f0 = n_fs; e0 = n_err; b0 = n_bad;
    mark = n_valid; mode = tab[i].mode; cur_rgb = tab[i].rgb;
    frame(tab[i].short_l);
    #1;
    chk($sformatf("r%0d_valid", i), n_valid - v0, tab[i].valid);
    chk($sformatf("r%0d_frame_start", i), n_fs - f0, tab[i].fs);
    chk($sformatf("r%0d_err", i), n_err - e0, tab[i].err);
    chk($sformatf("r%0d_bad_pix", i), n_bad - b0, 0);
    chk($sformatf("r%0d_locked", i), int'(bus.locked), tab[i].locked);
    if (tab[i].mode == 1) begin
      chk($sformatf("r%0d_first_x", i), int'(fx), 0);
      chk($sformatf("r%0d_first_y", i), int'(fy), 0);
      chk($sformatf("r%0d_last_x", i), int'(lx), HA - 1);
      chk($sformatf("r%0d_last_y", i), int'(ly), VA - 1);
      chk($sformatf("r%0d_last_rgb", i), int'(lrgb), 12'h730);
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int e0, pos;
    logic [15:0] exp_crc;
    tab[0]  = '{0, 12'hF5A, -1,  0, 0, 0, 0};
    tab[1]  = '{0, 12'hF5A, -1,  0, 0, 0, 0};
    tab[2]  = '{0, 12'hF5A, -1, 32, 1, 0, 1};
    tab[3]  = '{0, 12'hF5A, -1, 32, 1, 0, 1};
    tab[4]  = '{0, 12'hF5A,  5, 16, 1, 1, 0};
    tab[5]  = '{0, 12'hF5A, -1,  0, 0, 0, 0};
    tab[6]  = '{0, 12'hF5A, -1,  0, 0, 0, 0};
    tab[7]  = '{1, 12'h000, -1, 32, 1, 0, 1};
    tab[8]  = '{0, 12'h000, -1, 32, 1, 0, 1};
    tab[9]  = '{0, 12'h000, -1, 32, 1, 0, 1};
    tab[10] = '{0, 12'hF5A, -1,  0, 0, 0, 0};
    tab[11] = '{0, 12'hF5A, -1,  0, 0, 0, 0};
    tab[12] = '{0, 12'hF5A, -1, 32, 1, 0, 1};
    tab[13] = '{0, 12'h3C7, -1,  0, 0, 0, 0};
    tab[14] = '{0, 12'h3C7, -1,  0, 0, 0, 0};
    tab[15] = '{0, 12'h3C7, -1, 32, 1, 0, 1};
    bus.pix_stb = 1'b0;
    bus.hsync   = 1'b1;
    bus.vsync   = 1'b1;
    bus.rgb     = 12'h000;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", outs_nz(), 0);
    rst_n = 1'b1;
    repeat (4) strobe(1'b1, 1'b1, 12'h000);
    for (int i = 0; i < 10; i++) apply(i);
`ifdef VGA_DECODER_CRC_EN
    exp_crc = crc_zero_words(HA * VA);
`else
    exp_crc = 16'h0000;
`endif
    chk("frame_crc", int'(bus.frame_crc), int'(exp_crc));
    e0 = n_err;
    pos = 0;
    for (int j = 1; j <= 60; j++) begin
      strobe(1'b1, 1'b1, 12'h000);
      if (pos == 0 && n_err != e0) pos = j;
    end
    chk("timeout_strobe", pos, TO - HT + 1);
    chk("timeout_err_count", n_err - e0, 1);
    chk("timeout_locked", int'(bus.locked), 0);
    for (int i = 10; i < 13; i++) apply(i);
    fork
      frame(-1);
      begin
        repeat (355) @(posedge clk);
        #2;
        chk("pre_reset_locked", int'(bus.locked), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs_zero", outs_nz(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    for (int i = 13; i < NREC; i++) apply(i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
